// File: rtl/mac_pkg.sv
// Shared fixed-point definitions for the MAC result drain: default formats,
// derived widths and helpers for the quantizer shift and rounding constant.
package mac_pkg;

    localparam int MAC_INT_IN   = 10;
    localparam int MAC_FRAC_IN  = 22;
    localparam int MAC_INT_OUT  = 1;
    localparam int MAC_FRAC_OUT = 11;

    localparam int MAC_IN_W  = MAC_INT_IN + MAC_FRAC_IN;
    localparam int MAC_OUT_W = MAC_INT_OUT + MAC_FRAC_OUT;
    localparam int MAC_SHIFT = MAC_FRAC_IN - MAC_FRAC_OUT;
    localparam logic [MAC_IN_W:0] MAC_RND = (MAC_IN_W + 1)'(1) << (MAC_SHIFT - 1);

    typedef struct packed {
        logic                 sat;
        logic [MAC_OUT_W-1:0] data;
    } mac_entry_t;

    function automatic int shift_amount(input int frac_in, input int frac_out);
        return frac_in - frac_out;
    endfunction

    // Half an output LSB expressed in input LSBs; drives round-half-up.
    function automatic int round_bit(input int frac_in, input int frac_out);
        return shift_amount(frac_in, frac_out) - 1;
    endfunction

endpackage

// File: rtl/mac_result_fifo.sv
// Two-entry first-word-fall-through FIFO with a registered head output that
// holds its last value when empty; push and pop may coincide when full.
module mac_result_fifo #(
    parameter int WIDTH = 13
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] r_mem [2];
    logic [WIDTH-1:0] r_head;
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == 2'd2);
    assign empty_o = (r_count == 2'd0);
    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);
    assign data_o  = r_head;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= data_i;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 2'd1;
            end
            // Head follows the oldest live entry; an emptied FIFO keeps the last word.
            if (w_pop) begin
                if (full_o) begin
                    r_head <= r_mem[~r_rptr];
                end else if (w_push) begin
                    r_head <= data_i;
                end
            end else if (empty_o && w_push) begin
                r_head <= data_i;
            end
        end
    end

endmodule

// File: rtl/mac_result_drain.sv
// Keeps every len_p-th MAC result, rounds/saturates it to operand format and
// buffers it in a 2-entry FIFO. MAC_RESULT_DRAIN_SAT_COUNT_EN builds sat_count_o.
module mac_result_drain
    import mac_pkg::*;
#(
    parameter int int_in_p   = 10,
    parameter int frac_in_p  = 22,
    parameter int int_out_p  = 1,
    parameter int frac_out_p = 11,
    parameter int len_p      = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic                            valid_i,
    output logic                            ready_o,
    input  logic [int_in_p+frac_in_p-1:0]   data_i,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [int_out_p+frac_out_p-1:0] data_o,
    output logic                            sat_o,
    output logic [15:0]                     sat_count_o
);

    localparam int IN_W  = int_in_p + frac_in_p;
    localparam int OUT_W = int_out_p + frac_out_p;
    localparam int SUM_W = IN_W + 1;
    localparam int SHIFT = shift_amount(frac_in_p, frac_out_p);
    localparam int CNT_W = (len_p > 1) ? $clog2(len_p) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(len_p - 1);
    localparam logic [SUM_W-1:0] RND  = SUM_W'(1) << round_bit(frac_in_p, frac_out_p);

    typedef struct packed {
        logic             sat;
        logic [OUT_W-1:0] data;
    } entry_t;

    logic [CNT_W-1:0]        r_beat;
    logic                    w_last;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_shift;
    logic [SUM_W-OUT_W:0]    w_hi;
    entry_t                  w_entry;
    entry_t                  w_head;

    // A full FIFO still takes the final beat when the head leaves in the same cycle.
    assign w_last   = (r_beat == LAST);
    assign ready_o  = !w_last || !w_full || ready_i;
    assign w_accept = valid_i && ready_o;
    assign w_push   = w_accept && w_last;
    assign w_pop    = valid_o && ready_i;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_beat <= '0;
        end else if (w_accept) begin
            r_beat <= w_last ? '0 : r_beat + CNT_W'(1);
        end
    end

    assign w_sum   = $signed({data_i[IN_W-1], data_i}) + $signed(RND);
    assign w_shift = w_sum >>> SHIFT;
    assign w_hi    = w_shift[SUM_W-1:OUT_W-1];

    // Any disagreement among the bits above the output sign means overflow.
    always_comb begin
        w_entry.sat  = 1'b0;
        w_entry.data = w_shift[OUT_W-1:0];
        if (!(&w_hi) && (|w_hi)) begin
            w_entry.sat  = 1'b1;
            w_entry.data = w_shift[SUM_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                            : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    mac_result_fifo #(
        .WIDTH($bits(entry_t))
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .push_i  (w_push),
        .data_i  (w_entry),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign valid_o = !w_empty;
    assign data_o  = w_head.data;
    assign sat_o   = w_head.sat;

`ifdef MAC_RESULT_DRAIN_SAT_COUNT_EN
    logic [15:0] r_sat_count;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_sat_count <= 16'd0;
        end else if (w_push && w_entry.sat && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign sat_count_o = r_sat_count;
`else
    assign sat_count_o = 16'd0;
`endif

endmodule

// File: doc/mac_result_drain.md
Name: mac_result_drain

Overview:
- Downstream consumer of the MAC accumulator stream.
- Accepts wide fixed-point results (Q10.22 default) over ready/valid.
- Keeps only every len_p-th result (the end of a len_p-term dot product), rounds and saturates it to operand format (Q1.11 default), and buffers it in a 2-entry output FIFO so the MAC is never stalled on non-final beats.

Parameters:
- int_in_p, 10: integer bits of input (incl. sign)
- frac_in_p, 22: fractional bits of input
- int_out_p, 1: integer bits of output (incl. sign)
- frac_out_p, 11: fractional bits of output; must be < frac_in_p
- len_p, 16: accepted beats per emitted result; must be >= 1

Ports:
- clk_i  in  1  clock, rising edge
- reset_ni  in  1  asynchronous, active-low reset
- valid_i  in  1  MAC result valid
- ready_o  out  1  drain can accept data_i
- data_i  in  int_in_p+frac_in_p  signed MAC result, Q(int_in_p).(frac_in_p)
- valid_o  out  1  quantized result available
- ready_i  in  1  downstream accepts data_o
- data_o  out  int_out_p+frac_out_p  signed result, Q(int_out_p).(frac_out_p)
- sat_o  out  1  data_o was saturated; qualified by valid_o
- sat_count_o  out  16  saturation event count (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): beat counter=0, FIFO empty, valid_o=0, data_o=0, sat_o=0, sat_count_o=0. Reset mid-transfer discards buffered entries and the partial count.
- Input handshake: beat accepted when valid_i && ready_o. ready_o = (count != len_p-1) || !fifo_full. Non-final beats are always accepted and dropped. A final beat stalls only while the FIFO is full.
- Counter: increments on each accepted beat and wraps len_p-1 -> 0. With len_p=1, every beat is final.
- Final beat: quantized value and sat flag are written into the FIFO in the same cycle. Earliest valid_o is the next cycle (1-cycle latency).
- Quantization, round-half-up: sum = data_i + 2^(frac_in_p-frac_out_p-1), computed with 1 guard bit. Arithmetic shift right by frac_in_p-frac_out_p.
  - Result > max positive: data_o = 0b0111..1, sat=1.
  - Result < min negative: data_o = 0b1000..0, sat=1.
  - Otherwise truncate to output width, sat=0.
- FIFO: 2 entries, first-word-fall-through. data_o/sat_o are driven from the head, registered (no combinational path from data_i). valid_o = !empty. Pop on valid_o && ready_i.
  - Simultaneous push and pop when full is legal: ready_o stays high on a final beat if ready_i=1 that cycle. Computing this requires combinational ready_i -> ready_o only in the full case.
  - Pointers wrap modulo 2.
  - data_o holds its value when empty.
- No combinational path from valid_i to valid_o.

Optional Feature:
- Macro MAC_RESULT_DRAIN_SAT_COUNT_EN.
- Defined: 16-bit counter increments on each FIFO push with sat=1, saturates at 0xFFFF (no wrap), cleared only by reset. Drives sat_count_o.
- Undefined: counter not built; sat_count_o tied to 0.

Decomposition:
- Shared package mac_pkg: fixed-point width localparams (total input/output widths, shift amount = frac_in_p-frac_out_p, rounding constant) and a typedef for the FIFO entry struct {sat, data}.
- One sub-module: mac_result_fifo, the 2-entry FWFT FIFO (parameterized width, full/empty, simultaneous push/pop).
- Counter and quantizer stay in the top level.

Test Plan:
- Defaults, len_p=4: send 4 beats 0x000000,0x000000,0x000000,0x00200000 (0.5) with ready_i=1 -> one output, data_o=0x400, sat_o=0, valid_o exactly one cycle after the 4th handshake.
- Rounding: final beats 0x00000400 -> 0x001; 0x000003FF -> 0x000; 0xFFFFFC00 (-2^-12) -> 0x000; 0xFFFFFBFF -> 0xFFF.
- Saturation: final beats 0x00400000 (+1.0) -> 0x7FF sat=1; 0xFF800000 (-2.0) -> 0x800 sat=1; 0xFFE00000 (-0.5) -> 0xC00 sat=0. With macro defined, sat_count_o=2.
- Backpressure: ready_i=0, valid_i=1 continuously -> 2 results buffered, then ready_o=0 only at count=3. Raise ready_i -> outputs drain in order, no loss, no duplicates, count unaffected by stalls.
- Full with simultaneous pop: FIFO full, ready_i=1, final beat presented -> ready_o=1, push and pop in the same cycle, occupancy stays 2.
- Reset mid-stream: deassert reset_ni asynchronously after 2 beats with 1 entry buffered -> valid_o=0 immediately, ready_o=1. After release, the next 4 beats produce exactly one output.
